dig_ota_decim: RTL and testbench

DIG_OTA_DECIM -- requirements
Module: dig_ota_decim

---
 rtl/dig_ota_decim.sv | 116 +++++++++++
 tb/tb_dig_ota_decim.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dig_ota_decim.sv
// dig_ota_decim: 1-bit comparator decimator closing the digital OTA loop with a counting conversion.
// Define DIG_OTA_DECIM_MAJORITY_EN to add a 2-of-3 majority filter on the synchronized comparator.
module dig_ota_decim #(
  parameter int unsigned OSR_LOG2    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                comp_in,
  input  logic                start,
  output logic                dac_fb,
  output logic [OSR_LOG2-1:0] result,
  output logic                valid,
  output logic                busy
);

  localparam int unsigned AW = OSR_LOG2 + 1;
  localparam int unsigned CW = OSR_LOG2;
`ifdef DIG_OTA_DECIM_MAJORITY_EN
  localparam int unsigned SETTLE_LEN = SYNC_STAGES + 2;
`else
  localparam int unsigned SETTLE_LEN = SYNC_STAGES;
`endif
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_LEN - 1);
  localparam logic [CW-1:0] ACCUM_LAST  = CW'((1 << OSR_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                comp_s;
  logic [OSR_LOG2-1:0] sat;

  // Synchronizer chain on the asynchronous comparator decision
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], comp_in};
  end

`ifdef DIG_OTA_DECIM_MAJORITY_EN
  logic [1:0] maj_q;

  // Two older synchronized samples feed the 2-of-3 vote
  always_ff @(posedge clk) begin
    if (rst) maj_q <= '0;
    else     maj_q <= {maj_q[0], sync_q[SYNC_STAGES-1]};
  end

  assign comp_s = (sync_q[SYNC_STAGES-1] & maj_q[0]) |
                  (sync_q[SYNC_STAGES-1] & maj_q[1]) |
                  (maj_q[0] & maj_q[1]);
`else
  assign comp_s = sync_q[SYNC_STAGES-1];
`endif

  // Next-state, counter and accumulator; terminal counts are compares, never overflow
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ACCUM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ACCUM: begin
        acc_d = acc_q + AW'(comp_s);
        if (cnt_q == ACCUM_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A full-scale count of 2^OSR_LOG2 clips to the largest representable code
  assign sat = acc_d[OSR_LOG2] ? '1 : acc_d[OSR_LOG2-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dac_fb  <= 1'b0;
      result  <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dac_fb  <= comp_s;
      valid   <= (state_q == DONE);
      busy    <= (state_d == SETTLE) || (state_d == ACCUM);
      if (state_q == ACCUM && state_d == DONE) result <= sat;
    end
  end

endmodule

// File: tb/tb_dig_ota_decim.sv
// tb_dig_ota_decim: randomized bench with a per-edge sample history used as the reference model.
// Honours DIG_OTA_DECIM_MAJORITY_EN the same way as the design.
module tb_dig_ota_decim;

  localparam int unsigned OSR_LOG2 = 8;
  localparam int S = 2;
  localparam int N = 1 << OSR_LOG2;
`ifdef DIG_OTA_DECIM_MAJORITY_EN
  localparam int SL = S + 2;
`else
  localparam int SL = S;
`endif
  localparam int HN = 8192;

  logic clk = 1'b0;
  logic rst, comp_in, start;
  logic dac_fb, valid, busy;
  logic [OSR_LOG2-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int last_rst = 0;
  int mode     = 0;
  int exp_res  = 0;
  bit mon_en   = 1'b0;
  logic hist [HN];

  dig_ota_decim #(.OSR_LOG2(OSR_LOG2), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .comp_in(comp_in), .start(start),
    .dac_fb(dac_fb), .result(result), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // hist[k] is the comp_in value seen at rising edge k
  always @(posedge clk) begin
    hist[edge_n % HN] = comp_in;
    if (rst) last_rst = edge_n;
    edge_n = edge_n + 1;
  end

  // Comparator pattern generator
  always @(posedge clk) begin
    #1;
    case (mode)
      0: comp_in = 1'b0;
      1: comp_in = 1'b1;
      2: comp_in = ~comp_in;
      3: comp_in = 1'($urandom);
      default: comp_in = ((edge_n % 16) != 0);
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n - 1);
    end
  endtask

  // Decision the loop uses at edge m, derived from what comp_in was S edges earlier
  function automatic logic cs_at(input int m);
`ifdef DIG_OTA_DECIM_MAJORITY_EN
    logic a, b, c;
    a = hist[(m - S) % HN];
    b = hist[(m - S - 1) % HN];
    c = hist[(m - S - 2) % HN];
    return (a & b) | (a & c) | (b & c);
`else
    return hist[(m - S) % HN];
`endif
  endfunction

  // Loop feedback is the decision delayed by one register
  always @(negedge clk) begin
    if (mon_en && (edge_n - 1) > last_rst + S + 2)
      check("dac_fb", 32'(dac_fb), 32'(cs_at(edge_n - 1)));
  end

  task automatic start_conv(output int e0, input bit hold);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = edge_n - 1;
    if (!hold) start = 1'b0;
  endtask

  // Follows one conversion begun at edge e0 through its valid pulse
  task automatic track_conv(input int e0, input bit noise, input bit hold);
    int done_k;
    int sum;
    done_k = e0 + SL + N + 1;
    for (int k = e0; k <= done_k; k++) begin
      @(negedge clk);
      check("busy", 32'(busy), 32'(k < e0 + SL + N));
      check("valid", 32'(valid), 32'(k == done_k));
      if (k == e0 || k == e0 + SL + N - 1)
        check("result_hold", 32'(result), 32'(exp_res));
      if (!hold) start = (noise && k <= e0 + SL + N) ? 1'($urandom) : 1'b0;
    end
    sum = 0;
    for (int m = e0 + SL + 1; m <= e0 + SL + N; m++) sum += int'(cs_at(m));
    exp_res = (sum > N - 1) ? N - 1 : sum;
    check("result", 32'(result), 32'(exp_res));
  endtask

  task automatic idle_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'(0));
      check("idle_valid", 32'(valid), 32'(0));
    end
  endtask

  initial begin
    int e0;
    int e1;
    rst = 1'b1;
    start = 1'b0;
    comp_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_result", 32'(result), 32'(0));
    check("rst_valid", 32'(valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_dac_fb", 32'(dac_fb), 32'(0));
    rst = 1'b0;
    mon_en = 1'b1;
    idle_check(4);

    // Constant ones: count of 256 saturates to 255
    mode = 1;
    start_conv(e0, 1'b0);
    track_conv(e0, 1'b0, 1'b0);
    check("ones_sat", 32'(result), 32'(N - 1));
    idle_check(3);

    mode = 0;
    start_conv(e0, 1'b0);
    track_conv(e0, 1'b0, 1'b0);
    check("zeros", 32'(result), 32'(0));

    mode = 2;
    start_conv(e0, 1'b0);
    track_conv(e0, 1'b0, 1'b0);
    check("toggle_half", 32'(result), 32'(N / 2));

    // Random comparator with stray start pulses during the conversion
    mode = 3;
    for (int r = 0; r < 3; r++) begin
      start_conv(e0, 1'b0);
      track_conv(e0, 1'b1, 1'b0);
      idle_check(2);
    end

    mode = 4;
    start_conv(e0, 1'b0);
    track_conv(e0, 1'b0, 1'b0);
`ifdef DIG_OTA_DECIM_MAJORITY_EN
    check("glitch_filtered", 32'(result), 32'(N - 1));
`else
    check("glitch_raw", 32'(result), 32'(N - N / 16));
`endif

    // Reset during ACCUM aborts the conversion; reset wins over start
    mode = 3;
    start_conv(e0, 1'b0);
    for (int k = e0; k < e0 + 100; k++) begin
      @(negedge clk);
      check("pre_abort_busy", 32'(busy), 32'(1));
    end
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_valid", 32'(valid), 32'(0));
    check("abort_result", 32'(result), 32'(0));
    check("abort_dac_fb", 32'(dac_fb), 32'(0));
    rst = 1'b0;
    start = 1'b0;
    exp_res = 0;
    idle_check(300);

    mode = 1;
    start_conv(e0, 1'b0);
    track_conv(e0, 1'b0, 1'b0);
    check("post_abort", 32'(result), 32'(N - 1));

    // Start held high: back-to-back conversions restarting from IDLE
    mode = 3;
    start_conv(e0, 1'b1);
    track_conv(e0, 1'b0, 1'b1);
    e1 = e0 + SL + N + 2;
    track_conv(e1, 1'b0, 1'b0);
    idle_check(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
